// File: rtl/reg_file_pkg.sv
// Register-file write-port sharing: shared constants, types and a clog2 helper.
// No logic, no latency; no flow control of its own.
package reg_file_pkg;

   localparam int RF_ADDR_W   = 5;
   localparam int RF_DATA_W   = 32;
   localparam int RF_NUM_REGS = 32;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [RF_DATA_W-1:0] rf_data_t;

   // Never returns less than 1 so a 1-bit index still exists for tiny counts.
   function automatic int clog2(input int n);
      int v_w;
      v_w = 1;
      while ((1 << v_w) < n) begin
         v_w = v_w + 1;
      end
      return v_w;
   endfunction

endpackage

// File: rtl/reg_file_write_arbiter_rr_pick.sv
// Round-robin one-hot picker: first set request at or after the pointer, wrapping.
// Purely combinational, zero latency; no backpressure, the caller gates i_req.
module reg_file_write_arbiter_rr_pick
   import reg_file_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   always_comb begin
      int unsigned w_sum;
      logic [IDX_W-1:0] w_cand;
      logic w_found;
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_sum   = 0;
      w_cand  = '0;
      for (int off = 0; off < N; off++) begin
         // Explicit compare keeps the wrap correct when N is not a power of two.
         w_sum = int'(unsigned'(i_ptr)) + off;
         if (w_sum >= N) begin
            w_sum = w_sum - N;
         end
         w_cand = IDX_W'(w_sum);
         if (!w_found && i_req[w_cand]) begin
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
            w_found         = 1'b1;
         end
      end
      o_any = w_found;
   end

endmodule

// File: rtl/reg_file_write_arbiter.sv
// Round-robin arbiter for the single register-file write port; RF_ZERO_REG_DISCARD_EN drops x0 writes.
// Latency: 1 cycle accept -> wr_en. Backpressure: wr_stall freezes the output stage and withholds req_ready.
module reg_file_write_arbiter
   import reg_file_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = RF_ADDR_W,
   parameter int DATA_W  = RF_DATA_W,
   parameter int IDX_W   = clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      wr_stall,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy
);

   logic [IDX_W-1:0]   r_ptr;
   logic               r_wr_en;
   logic [ADDR_W-1:0]  r_wr_addr;
   logic [DATA_W-1:0]  r_wr_data;
   logic [IDX_W-1:0]   r_grant_id;

   logic [NUM_REQ-1:0] w_req;
   logic [NUM_REQ-1:0] w_grant;
   logic [IDX_W-1:0]   w_idx;
   logic               w_any;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic [DATA_W-1:0]  w_sel_data;
   logic               w_load_en;

   // No grant while stalled or held in reset.
   assign w_req = (wr_stall || !rst_n) ? '0 : req_valid;

   reg_file_write_arbiter_rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   always_comb begin
      w_sel_addr = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            w_sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_ptr_nxt = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

`ifdef RF_ZERO_REG_DISCARD_EN
   // x0 is hardwired zero: accept the request but spend no file cycle on it.
   assign w_load_en = (w_sel_addr != '0);
`else
   assign w_load_en = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_grant_id <= '0;
      end else if (!wr_stall) begin
         if (w_any) begin
            r_wr_en    <= w_load_en;
            r_wr_addr  <= w_sel_addr;
            r_wr_data  <= w_sel_data;
            r_grant_id <= w_idx;
            r_ptr      <= w_ptr_nxt;
         end else begin
            r_wr_en    <= 1'b0;
         end
      end
   end

   assign req_ready = w_grant;
   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign grant_id  = r_grant_id;
   assign busy      = (|req_valid) | r_wr_en;

endmodule

// File: doc/reg_file_write_arbiter.md
Name: reg_file_write_arbiter

Overview:
- Shares the single write port of the 32 x 32-bit register file between NUM_REQ requesters, e.g. ALU writeback, load writeback and CSR/debug.
- Round-robin arbitration with per-requester valid/ready handshake.
- The granted write is registered and presented to the register file one cycle later. wr_addr drives the file's 5-to-32 write decoder; wr_en gates the decoder enable.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, register data width

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant; the write is accepted when valid and ready are both high
wr_stall  input  1  register file cannot take a write this cycle
wr_en  output  1  write strobe to the register file
wr_addr  output  ADDR_W  write address to the register file decoder
wr_data  output  DATA_W  write data
grant_id  output  clog2(NUM_REQ)  index of the requester whose write is on wr_*
busy  output  1  any req_valid high this cycle, or wr_en high

Behaviour:
- Reset (asynchronous on rst_n low): wr_en=0, wr_addr=0, wr_data=0, grant_id=0, round-robin pointer=0. req_ready is combinational, so it is 0 while rst_n is low.
- Arbitration (combinational):
  - When wr_stall=0, scan req_valid starting at the pointer, wrapping modulo NUM_REQ.
  - The first valid requester gets req_ready=1; all others get 0.
  - When wr_stall=1 or no request is valid, req_ready is all zero.
- Accept (clock edge with a grant to requester k):
  - wr_en<=1, wr_addr<=req_addr[k], wr_data<=req_data[k], grant_id<=k.
  - Pointer <= (k+1) mod NUM_REQ.
- No grant and wr_stall=0: wr_en<=0; wr_addr, wr_data and grant_id hold; pointer holds.
- wr_stall=1:
  - Output stage holds all values, including wr_en. A write already presented stays presented until wr_stall drops.
  - No new grant is issued and the pointer holds.
- Latency: exactly 1 cycle from accept to wr_en. Throughput: 1 write per cycle when not stalled.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- Same-address requests in one cycle: only the winner is written. The loser keeps valid asserted and is written in a later cycle, so the last-granted write wins. No merging.
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not check this.
- Reset asserted mid-operation: any write on wr_* is dropped (wr_en=0 immediately); nothing is replayed.
- NUM_REQ not a power of two: pointer wrap uses an explicit compare, not bit truncation.

Optional Feature:
- Macro RF_ZERO_REG_DISCARD_EN.
- Defined:
  - A granted request with addr=0 is accepted normally (ready=1, pointer advances), but the output stage loads wr_en=0.
  - Register x0 is therefore never written and no file cycle is spent on it.
- Undefined: address 0 is written like any other register.

Decomposition:
- Package reg_file_pkg:
  - constants RF_ADDR_W=5, RF_DATA_W=32, RF_NUM_REGS=32;
  - a clog2 function;
  - typedefs rf_addr_t and rf_data_t.
- Sub-module rr_pick: purely combinational one-hot round-robin picker. Inputs: req vector and pointer. Outputs: one-hot grant, index, any.
- The top level holds the pointer, output stage and stall logic.

Test Plan:
- Reset then single request: req_valid=0001, addr0=5'd13, data0=32'hDEAD_BEEF -> ready=0001 the same cycle; next cycle wr_en=1, wr_addr=13, wr_data=DEADBEEF, grant_id=0.
- All four valid continuously (addr i = i+1) -> grant order 0,1,2,3,0 on successive cycles; wr_en stays high; wr_addr sequence 1,2,3,4,1.
- Stall: a write to addr 7 is on the outputs and wr_stall=1 for 3 cycles -> wr_en=1 with addr 7 held for 3 cycles; req_ready=0; pointer unchanged; the next grant follows the cycle after the stall drops.
- Same address: requesters 1 and 2 both write addr 9 with data 11 and 22, pointer=2 -> 22 written first, then 11; final register value 11.
- Reset mid-write: rst_n low while wr_en=1 -> wr_en=0 asynchronously; after release the pointer is 0, so requester 0 wins a 4-way contest.
- With RF_ZERO_REG_DISCARD_EN: a request to addr 0 gets ready=1 and the pointer advances, but wr_en stays 0. Without the macro -> wr_en=1, wr_addr=0.
